mem_arbiter: RTL and testbench

- Shares the single memory port between two requesters:
  - the instruction-fetch side of the control path;
  - the data load/store side of the datapath.
- Two-way round-robin arbitration, one outstanding transaction at a time, variable-latency memory handshake with timeout.
- Sits between the control path/datapath and memory; gives the CPU explicit grant/valid signals for fetch and data.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter_rr_arb2.sv | 44 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the two-requester memory arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY_IF, BUSY_D)
//   req_e   : requester identity, used for the last-granted pointer
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake/bus signal around the arbiter.
//   Fetch side : if_req, if_addr -> if_gnt, if_valid, if_rdata
//   Data side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   Status     : err (timeout pulse), busy (transaction in flight)
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding CPU + memory environment's view
interface mem_arbiter_if #(
    parameter int REG_WIDTH = 16
) ();

    logic                 if_req;
    logic [REG_WIDTH-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_valid;
    logic [REG_WIDTH-1:0] if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [REG_WIDTH-1:0] d_addr;
    logic [REG_WIDTH-1:0] d_wdata;
    logic                 d_gnt;
    logic                 d_valid;
    logic [REG_WIDTH-1:0] d_rdata;

    logic                 mem_req;
    logic                 mem_we;
    logic [REG_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0] mem_wdata;
    logic [REG_WIDTH-1:0] mem_rdata;
    logic                 mem_ack;

    logic                 err;
    logic                 busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output err, busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  err, busy
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant logic.
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : arbitration allowed this cycle
//   req_if, req_d   : level requests
//   gnt_if, gnt_d   : combinational one-hot (or zero) grants
// The last-granted pointer resets to REQ_D so fetch wins the first contention.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    req_e last_q;

    // Under contention the requester that was not served last time wins.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (en) begin
            if (req_if && (!req_d || last_q == REQ_D)) begin
                gnt_if = 1'b1;
            end else if (req_d) begin
                gnt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= REQ_D;
        end else if (gnt_if) begin
            last_q <= REQ_IF;
        end else if (gnt_d) begin
            last_q <= REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store. One transaction at a time, round-robin under contention,
// variable-latency memory handshake with a MAX_WAIT-cycle timeout.
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave carrying fetch, data, memory and status signals
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int MAX_WAIT  = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_BUSY_IF = BUSY_IF;
    localparam logic [1:0] ST_BUSY_D  = BUSY_D;

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    // Counter value seen on the MAX_WAIT-th busy cycle (it starts at zero).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [1:0]           state_q;
    logic [CNT_W-1:0]     wait_q;
    logic [REG_WIDTH-1:0] addr_q;
    logic                 we_q;
    logic [REG_WIDTH-1:0] wdata_q;
    logic [REG_WIDTH-1:0] if_rdata_q;
    logic [REG_WIDTH-1:0] d_rdata_q;
    logic                 if_valid_q;
    logic                 d_valid_q;
    logic                 err_q;

    logic idle;
    logic busy;
    logic gnt_if;
    logic gnt_d;

    assign idle = (state_q == ST_IDLE);
    assign busy = !idle;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (idle),
        .req_if (bus.if_req),
        .req_d  (bus.d_req),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    // FSM, timeout counter, completion pulses and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_if) begin
                        state_q <= ST_BUSY_IF;
                        wait_q  <= '0;
                    end else if (gnt_d) begin
                        state_q <= ST_BUSY_D;
                        wait_q  <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (bus.mem_ack) begin
                        state_q <= ST_IDLE;
                        if (state_q == ST_BUSY_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            // Stores complete without touching the load result.
                            if (!we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                            d_valid_q <= 1'b1;
                        end
                    end else if (wait_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Request attributes latched at grant; only observed while busy,
    // so they need no reset.
    always_ff @(posedge clk) begin
        if (gnt_if) begin
            addr_q  <= bus.if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (gnt_d) begin
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy;

    // Memory-side outputs are forced to zero outside a transaction.
    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy & we_q;
    assign bus.mem_addr  = busy ? addr_q  : '0;
    assign bus.mem_wdata = busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W    = 16;
    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.REG_WIDTH(W)) bus ();

    mem_arbiter #(.REG_WIDTH(W), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle stimulus, set by the directed steps / random loop.
    bit           g_rst_n, g_ireq, g_dreq, g_dwe, g_xack;
    logic [W-1:0] g_iaddr, g_daddr, g_dwd, g_rd;
    int           g_lat;   // ack on busy cycle g_lat+1; >= MAXW means never ack

    // Transaction-level reference model (cycle numbers, not FSM states).
    int           cyc, busy_end, ack_cyc, done_cyc;
    bit           last_d, t_d, t_we, t_to;
    logic [W-1:0] t_addr, t_wdata, ack_data, exp_if_rd, exp_d_rd;

    // Observation tallies used by the directed steps.
    int n_req_hi, n_err, n_ifv, n_dv;
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_tally();
        n_req_hi = 0; n_err = 0; n_ifv = 0; n_dv = 0;
        gq.delete();
    endtask

    task automatic model_reset();
        busy_end = -1; ack_cyc = -1; done_cyc = -1;
        last_d = 1'b1; exp_if_rd = '0; exp_d_rd = '0;
    endtask

    // One clock cycle: drive inputs at posedge+1, check at posedge+4,
    // advance the model, then wait for the next posedge+1.
    task automatic cycle();
        bit idle, w_if, w_d, e_ifv, e_dv, e_err;
        int nb;
        idle  = (cyc > busy_end);
        e_ifv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
        if (cyc == done_cyc) begin
            if (t_to) e_err = 1'b1;
            else if (!t_d) begin e_ifv = 1'b1; exp_if_rd = ack_data; end
            else begin
                e_dv = 1'b1;
                if (!t_we) exp_d_rd = ack_data;
            end
        end

        rst_n         = g_rst_n;
        bus.if_req    = g_ireq;
        bus.if_addr   = g_iaddr;
        bus.d_req     = g_dreq;
        bus.d_we      = g_dwe;
        bus.d_addr    = g_daddr;
        bus.d_wdata   = g_dwd;
        bus.mem_ack   = (cyc == ack_cyc) || (idle && g_xack);
        bus.mem_rdata = (cyc == ack_cyc) ? ack_data : W'($urandom);

        w_if = 1'b0; w_d = 1'b0;
        if (idle) begin
            if (g_ireq && (!g_dreq || last_d)) w_if = 1'b1;
            else if (g_dreq) w_d = 1'b1;
        end

        #3;
        chk("if_gnt",   bus.if_gnt,   w_if);
        chk("d_gnt",    bus.d_gnt,    w_d);
        chk("busy",     bus.busy,     !idle);
        chk("mem_req",  bus.mem_req,  !idle);
        chk("if_valid", bus.if_valid, e_ifv);
        chk("d_valid",  bus.d_valid,  e_dv);
        chk("err",      bus.err,      e_err);
        chk("if_rdata", bus.if_rdata, exp_if_rd);
        chk("d_rdata",  bus.d_rdata,  exp_d_rd);
        if (!idle) begin
            chk("mem_addr",  bus.mem_addr,  t_addr);
            chk("mem_we",    bus.mem_we,    t_we);
            chk("mem_wdata", bus.mem_wdata, t_wdata);
        end
        if (bus.mem_req === 1'b1)  n_req_hi++;
        if (bus.err === 1'b1)      n_err++;
        if (bus.if_valid === 1'b1) n_ifv++;
        if (bus.d_valid === 1'b1)  n_dv++;

        if (w_if || w_d) begin
            gq.push_back(w_d ? 1 : 0);
            t_d     = w_d;
            t_addr  = w_d ? g_daddr : g_iaddr;
            t_we    = w_d && g_dwe;
            t_wdata = w_d ? g_dwd : '0;
            last_d  = w_d;
            if (g_lat < MAXW) begin
                nb = g_lat + 1; t_to = 1'b0;
                ack_cyc = cyc + nb; ack_data = g_rd;
            end else begin
                nb = MAXW; t_to = 1'b1; ack_cyc = -1;
            end
            busy_end = cyc + nb;
            done_cyc = busy_end + 1;
        end
        if (!g_rst_n) model_reset();

        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle_n(input int n);
        g_ireq = 1'b0; g_dreq = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        g_rst_n = 1'b1; g_ireq = 1'b0; g_dreq = 1'b0; g_dwe = 1'b0; g_xack = 1'b0;
        g_iaddr = '0; g_daddr = '0; g_dwd = '0; g_rd = '0; g_lat = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",     bus.busy,      1'b0);
        chk("rst_mem_req",  bus.mem_req,   1'b0);
        chk("rst_mem_we",   bus.mem_we,    1'b0);
        chk("rst_mem_addr", bus.mem_addr,  '0);
        chk("rst_if_valid", bus.if_valid,  1'b0);
        chk("rst_d_valid",  bus.d_valid,   1'b0);
        chk("rst_err",      bus.err,       1'b0);
        chk("rst_if_rdata", bus.if_rdata,  '0);
        chk("rst_d_rdata",  bus.d_rdata,   '0);
        cyc = 0;
        model_reset();
        clr_tally();

        // Fetch with memory acking two cycles after mem_req rises
        g_ireq = 1'b1; g_iaddr = 16'h0010; g_lat = 2; g_rd = 16'hA5C3;
        cycle();
        idle_n(4);
        chk("t1_if_rdata", bus.if_rdata, 16'hA5C3);
        chk("t1_nvalid",   n_ifv,        1);

        // Continuous contention, zero-wait memory, fresh from reset
        g_rst_n = 1'b0; idle_n(1); g_rst_n = 1'b1;
        clr_tally();
        g_lat = 0;
        for (int i = 0; i < 8; i++) begin
            g_ireq = 1'b1; g_dreq = 1'b1; g_dwe = 1'b0;
            g_iaddr = W'($urandom); g_daddr = W'($urandom); g_rd = W'($urandom);
            cycle();
        end
        idle_n(2);
        chk("t2_ngrants", gq.size(), 4);
        for (int i = 0; i < gq.size(); i++) chk("t2_order", gq[i], i % 2);
        chk("t2_if_valids", n_ifv, 2);
        chk("t2_d_valids",  n_dv,  2);

        // Store leaves the load result untouched
        clr_tally();
        r = int'(exp_d_rd);
        g_dreq = 1'b1; g_dwe = 1'b1; g_daddr = 16'h0200; g_dwd = 16'hBEEF;
        g_lat = 3; g_rd = 16'h0BAD;
        cycle();
        idle_n(5);
        g_dwe = 1'b0;
        chk("t3_d_rdata_kept", bus.d_rdata, r[W-1:0]);
        chk("t3_nvalid",       n_dv,        1);

        // Timeout: memory never acks
        clr_tally();
        g_ireq = 1'b1; g_iaddr = 16'h0040; g_lat = MAXW;
        cycle();
        idle_n(MAXW + 3);
        chk("t4_req_cycles", n_req_hi, MAXW);
        chk("t4_err_pulses", n_err,    1);
        chk("t4_no_valid",   n_ifv,    0);
        chk("t4_busy_after", bus.busy, 1'b0);
        clr_tally();
        g_ireq = 1'b1; g_iaddr = 16'h0044; g_lat = 1; g_rd = 16'h1234;
        cycle();
        idle_n(4);
        chk("t4_next_rdata", bus.if_rdata, 16'h1234);
        chk("t4_next_valid", n_ifv,        1);

        // Reset mid data transaction, late acks while idle
        clr_tally();
        g_dreq = 1'b1; g_dwe = 1'b0; g_daddr = 16'h0300; g_lat = 10; g_rd = 16'h7777;
        cycle();
        idle_n(3);
        g_rst_n = 1'b0; idle_n(1); g_rst_n = 1'b1;
        g_xack = 1'b1; idle_n(10); g_xack = 1'b0;
        chk("t5_no_dvalid", n_dv,        0);
        chk("t5_no_err",    n_err,       0);
        chk("t5_d_rdata",   bus.d_rdata, '0);
        gq.delete();
        g_ireq = 1'b1; g_dreq = 1'b1; g_lat = 0;
        cycle();
        idle_n(3);
        chk("t5_first_is_if", (gq.size() > 0) ? gq[0] : -1, 0);

        // Ack on exactly the last permitted busy cycle
        clr_tally();
        g_ireq = 1'b1; g_iaddr = 16'h0080; g_lat = MAXW - 1; g_rd = 16'h5A5A;
        cycle();
        idle_n(MAXW + 3);
        chk("t6_req_cycles", n_req_hi,     MAXW);
        chk("t6_no_err",     n_err,        0);
        chk("t6_valid",      n_ifv,        1);
        chk("t6_if_rdata",   bus.if_rdata, 16'h5A5A);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            g_ireq  = 1'($urandom_range(0, 1));
            g_dreq  = 1'($urandom_range(0, 1));
            g_dwe   = 1'($urandom_range(0, 1));
            g_iaddr = W'($urandom); g_daddr = W'($urandom);
            g_dwd   = W'($urandom); g_rd    = W'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 70)      g_lat = int'($urandom_range(0, 3));
            else if (r < 92) g_lat = int'($urandom_range(4, MAXW - 1));
            else             g_lat = MAXW;
            g_xack  = ($urandom_range(0, 3) == 0);
            g_rst_n = ($urandom_range(0, 99) != 0);
            if (!g_rst_n) begin g_ireq = 1'b0; g_dreq = 1'b0; g_xack = 1'b0; end
            cycle();
        end
        g_rst_n = 1'b1; g_xack = 1'b0;
        idle_n(MAXW + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
